// File: rtl/io_ports_pcint.sv
// Memory-mapped I/O ports: direction/output/input registers, 2-flop input synchroniser,
// PIN-write toggle of PORT and per-port pin-change interrupt with write-1-to-clear flags.
module io_ports_pcint #(
  parameter int NUM_PORTS  = 3,
  parameter int PORT_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [PORT_WIDTH-1:0]            data_in,
  input  logic                             write_enable,
  inout  wire  [NUM_PORTS*PORT_WIDTH-1:0]  io_port,
  output logic [PORT_WIDTH-1:0]            data_out,
  output logic [NUM_PORTS-1:0]             irq
);

  localparam int NUM_REGS = NUM_PORTS * 5;

  logic                  in_range;
  logic [ADDR_WIDTH-1:0] addr_port;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [PORT_WIDTH-1:0] rd_data [NUM_PORTS];

  // Address = port*5 + register; constant divide/modulo maps to plain logic.
  assign in_range  = {1'b0, address} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign addr_port = address / ADDR_WIDTH'(5);
  assign addr_reg  = address % ADDR_WIDTH'(5);

  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [PORT_WIDTH-1:0] ddr_q, ddr_d;
      logic [PORT_WIDTH-1:0] port_q, port_d;
      logic [PORT_WIDTH-1:0] pcmsk_q, pcmsk_d;
      logic [PORT_WIDTH-1:0] pcif_q, pcif_d;
      logic [PORT_WIDTH-1:0] s1_q, pin_q;
      logic                  port_hit;

      assign port_hit = in_range && (addr_port == ADDR_WIDTH'(gi));

      always_comb begin
        ddr_d   = ddr_q;
        port_d  = port_q;
        pcmsk_d = pcmsk_q;
        pcif_d  = pcif_q;
        if (write_enable && port_hit) begin
          case (addr_reg)
            ADDR_WIDTH'(0): ddr_d   = data_in;
            ADDR_WIDTH'(1): port_d  = data_in;
            ADDR_WIDTH'(2): port_d  = port_q ^ data_in;
            ADDR_WIDTH'(3): pcmsk_d = data_in;
            ADDR_WIDTH'(4): pcif_d  = pcif_q & ~data_in;
            default: ;
          endcase
        end
        // Set is OR-ed after the clear so a same-cycle event wins over write-1-to-clear.
        pcif_d = pcif_d | ((s1_q ^ pin_q) & pcmsk_q);
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ddr_q   <= '0;
          port_q  <= '0;
          pcmsk_q <= '0;
          pcif_q  <= '0;
          s1_q    <= '0;
          pin_q   <= '0;
        end else begin
          ddr_q   <= ddr_d;
          port_q  <= port_d;
          pcmsk_q <= pcmsk_d;
          pcif_q  <= pcif_d;
          s1_q    <= io_port[gi*PORT_WIDTH +: PORT_WIDTH];
          pin_q   <= s1_q;
        end
      end

      assign irq[gi] = |pcif_q;

      always_comb begin
        rd_data[gi] = '0;
        if (port_hit) begin
          case (addr_reg)
            ADDR_WIDTH'(0): rd_data[gi] = ddr_q;
            ADDR_WIDTH'(1): rd_data[gi] = port_q;
            ADDR_WIDTH'(2): rd_data[gi] = pin_q;
            ADDR_WIDTH'(3): rd_data[gi] = pcmsk_q;
            ADDR_WIDTH'(4): rd_data[gi] = pcif_q;
            default:        rd_data[gi] = '0;
          endcase
        end
      end

      for (gb = 0; gb < PORT_WIDTH; gb++) begin : g_bit
        assign io_port[gi*PORT_WIDTH + gb] = ddr_q[gb] ? port_q[gb] : 1'bz;
      end
    end
  endgenerate

  always_comb begin
    data_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_out = data_out | rd_data[p];
    end
  end

endmodule

// File: tb/tb_io_ports_pcint.sv
// Bench for io_ports_pcint: register-level model with a pad sample history, checked every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_io_ports_pcint;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [W-1:0]  data_in = '0;
  logic          write_enable = 1'b0;
  wire  [NP*W-1:0] io_port;
  logic [W-1:0]  data_out;
  logic [NP-1:0] irq;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  logic [W-1:0] tb_val [NP];

  // Model state: registers plus the two most recent pad samples (newest first).
  logic [W-1:0] m_ddr [NP];
  logic [W-1:0] m_port [NP];
  logic [W-1:0] m_pcmsk [NP];
  logic [W-1:0] m_pcif [NP];
  logic [W-1:0] m_hist0 [NP];
  logic [W-1:0] m_hist1 [NP];

  io_ports_pcint #(.NUM_PORTS(NP), .PORT_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in),
    .write_enable(write_enable), .io_port(io_port), .data_out(data_out), .irq(irq)
  );

  always #5 clock = ~clock;

  // The bench drives every pad bit the model says the DUT leaves undriven.
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_drv
      for (genvar gb = 0; gb < W; gb++) begin : g_b
        assign io_port[gi*W + gb] = m_ddr[gi][gb] ? 1'bz : tb_val[gi][gb];
      end
    end
  endgenerate

  function automatic logic [W-1:0] pad_exp(int p);
    return (m_ddr[p] & m_port[p]) | (~m_ddr[p] & tb_val[p]);
  endfunction

  function automatic bit wr_hit(int p, int r);
    int a;
    a = int'(address);
    return write_enable && (a < NP*5) && (a / 5 == p) && (a % 5 == r);
  endfunction

  function automatic logic [W-1:0] m_read(logic [AW-1:0] addr);
    int a;
    a = int'(addr);
    if (a >= NP*5) return '0;
    case (a % 5)
      0: return m_ddr[a/5];
      1: return m_port[a/5];
      2: return m_hist1[a/5];
      3: return m_pcmsk[a/5];
      default: return m_pcif[a/5];
    endcase
  endfunction

  function automatic logic [NP-1:0] m_irq();
    logic [NP-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p] = (m_pcif[p] != '0);
    return v;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_ddr[p] <= '0; m_port[p] <= '0; m_pcmsk[p] <= '0;
        m_pcif[p] <= '0; m_hist0[p] <= '0; m_hist1[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        m_hist0[p] <= pad_exp(p);
        m_hist1[p] <= m_hist0[p];
        m_pcif[p]  <= (m_pcif[p] & ~(wr_hit(p, 4) ? data_in : '0))
                    | ((m_hist0[p] ^ m_hist1[p]) & m_pcmsk[p]);
        if (wr_hit(p, 0)) m_ddr[p] <= data_in;
        if (wr_hit(p, 1)) m_port[p] <= data_in;
        if (wr_hit(p, 2)) m_port[p] <= m_port[p] ^ data_in;
        if (wr_hit(p, 3)) m_pcmsk[p] <= data_in;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pad_of(int p);
    return io_port[p*W +: W];
  endfunction

  always @(negedge clock) begin
    if (started) begin
      check("cyc_data_out", 32'(data_out), 32'(m_read(address)));
      check("cyc_irq", 32'(irq), 32'(m_irq()));
      for (int p = 0; p < NP; p++) check("cyc_pad", 32'(pad_of(p)), 32'(pad_exp(p)));
    end
  end

  task automatic wr(logic [AW-1:0] a, logic [W-1:0] d);
    address = a; data_in = d; write_enable = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic rd_check(string name, logic [AW-1:0] a, logic [W-1:0] exp);
    address = a; #1;
    check(name, 32'(data_out), 32'(exp));
    $display("read  addr=%0d data=%h", a, data_out);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) tb_val[p] = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; started = 1'b1;

    // Drive port 0, then reset in the middle of a cycle.
    wr(8'd0, 8'hFF);
    wr(8'd1, 8'hA5);
    check("pad0_driven", 32'(pad_of(0)), 32'h0000_00A5);
    rd_check("port0_read", 8'd1, 8'hA5);
    tb_val[0] = 8'h5A;
    reset = 1'b1; #1;
    check("rst_port0_read", 32'(data_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pad0_released", 32'(pad_of(0)), 32'h0000_005A);
    @(posedge clock); #1;
    tb_val[0] = 8'h00;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clock); #1; end

    // Direction + synchroniser latency.
    wr(8'd0, 8'hFF);
    wr(8'd1, 8'h3C);
    check("pad0_3c", 32'(pad_of(0)), 32'h0000_003C);
    @(posedge clock); #1;
    rd_check("pin0_one_cycle", 8'd2, 8'h00);
    @(posedge clock); #1;
    rd_check("pin0_two_cycles", 8'd2, 8'h3C);

    // PIN write toggles PORT.
    wr(8'd6, 8'h0F);
    wr(8'd5, 8'hFF);
    wr(8'd7, 8'hFF);
    rd_check("port1_toggled", 8'd6, 8'hF0);
    check("pad1_toggled", 32'(pad_of(1)), 32'h0000_00F0);

    // Pin change on port 2 bit 0.
    wr(8'd13, 8'h01);
    address = 8'd14;
    tb_val[2] = 8'h01;
    @(posedge clock); #1;
    rd_check("pcif2_one_cycle", 8'd14, 8'h00);
    check("irq2_one_cycle", 32'(irq[2]), 32'h0);
    @(posedge clock); #1;
    rd_check("pcif2_set", 8'd14, 8'h01);
    check("irq2_set", 32'(irq[2]), 32'h1);

    // Unmasked bit changes do not flag.
    tb_val[2] = 8'h03;
    repeat (3) begin @(posedge clock); #1; end
    rd_check("pcif2_unmasked", 8'd14, 8'h01);

    // Clear racing a new set event on bit 0.
    tb_val[2] = 8'h02;
    @(posedge clock); #1;
    wr(8'd14, 8'h01);
    rd_check("pcif2_race", 8'd14, 8'h01);
    wr(8'd14, 8'h01);
    rd_check("pcif2_cleared", 8'd14, 8'h00);
    check("irq2_cleared", 32'(irq[2]), 32'h0);

    // Out of range.
    wr(8'd15, 8'hFF);
    rd_check("oor_read", 8'd15, 8'h00);
    rd_check("ddr0_unchanged", 8'd0, 8'hFF);
    rd_check("pcmsk2_unchanged", 8'd13, 8'h01);
    rd_check("pcif2_addr14", 8'd14, 8'h00);
    repeat (3) begin @(posedge clock); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_ports_pcint.md
Name: io_ports_pcint

Overview:
- Parametrised I/O-register block: NUM_PORTS ports, each PORT_WIDTH bits wide.
- Each port has a data-direction register (DDR), a port register (PORT), a pin register (PIN), a pin-change mask (PCMSK) and a pin-change flag register (PCIF).
- Adds over the previous I/O memory: 2-flop input synchroniser, PIN-write toggle of PORT, and per-port pin-change interrupt with write-1-to-clear flags.
- Sits on the CPU data bus beside data memory and feeds the interrupt controller.

Parameters:
NUM_PORTS, 3, number of I/O ports (1..16)
PORT_WIDTH, 8, bits per port and data-bus width (1..32)
ADDR_WIDTH, 8, address bus width; NUM_PORTS*5 must be <= 2**ADDR_WIDTH

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
address  input  ADDR_WIDTH  register address for read/write
data_in  input  PORT_WIDTH  write data
write_enable  input  1  write strobe; one write per cycle at clock edge
io_port  inout  NUM_PORTS*PORT_WIDTH  pads; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH]
data_out  output  PORT_WIDTH  combinational read data for address
irq  output  NUM_PORTS  per-port pin-change interrupt request

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Address map: address = p*5 + r. Register r values:
  - 0 = DDR
  - 1 = PORT
  - 2 = PIN
  - 3 = PCMSK
  - 4 = PCIF
- Addresses >= NUM_PORTS*5: reads return 0; writes are ignored.
- Reset (asserted at any time, including mid-operation): DDR, PORT, PIN, PCMSK, PCIF and sync stage 1 all clear to 0 immediately. Consequences: all pads Hi-Z, irq = 0, data_out = 0.
- Pad drive (per bit): DDR=1 drives the PORT bit; DDR=0 is Hi-Z. Purely combinational from the registers.
- Input sync:
  - s1 <= pad; PIN <= s1 on every clock.
  - Pad-to-PIN latency is 2 cycles.
  - Pads are sampled regardless of DDR, so output pins read back their driven value.
- Pin-change detect:
  - change = s1 XOR PIN, sampled in the cycle PIN updates.
  - PCIF[b] <= 1 when change[b] & PCMSK[b].
  - Flag sets 2 cycles after the pad edge.
  - Both edges count.
- Writes (write_enable=1, address in range), effective at the next clock edge:
  - DDR, PORT, PCMSK: loaded with data_in.
  - PIN: register itself is not writable. Each 1 bit in data_in toggles the matching PORT bit; 0 bits leave it unchanged.
  - PCIF: write-1-to-clear. If a set event hits the same bit in the same cycle, the set wins and the bit stays 1.
  - A new PCMSK value gates detection from the next cycle. Changes already flagged are not cleared by unmasking.
- irq[p] = OR-reduction of PCIF[p]. Combinational from registers, so irq asserts in the same cycle the flag is visible.
- data_out = selected register, combinational. No read side effects.
- Widths: all registers are PORT_WIDTH bits. Address decode divides by the constant 5 and must be synthesisable.

Test Plan:
- Reset and direction:
  - Assert reset mid-run with DDR0=8'hFF, PORT0=8'hA5 -> pads immediately Z, all reads 0, irq=0.
  - Release reset; write DDR0=8'hFF, PORT0=8'h3C -> port0 pads 8'h3C next cycle; PIN0 reads 8'h3C two cycles later.
- Toggle:
  - PORT1=8'h0F, DDR1=8'hFF, write 8'hFF to PIN1 -> PORT1 reads 8'hF0; pads 8'hF0 next cycle.
- Pin change:
  - PCMSK2=8'h01, DDR2=0; drive pad2[0] 0->1 -> PCIF2=8'h01 and irq[2]=1 exactly 2 cycles after the edge.
  - Toggle unmasked pad2[1] -> no flag.
- Clear race:
  - Write 8'h01 to PCIF2 in the same cycle a new masked change sets bit 0 -> PCIF2 stays 8'h01.
  - Clear with no event -> 8'h00, irq[2]=0.
- Out of range (NUM_PORTS=3):
  - Write to address 15 -> no register changes.
  - Read address 15 -> 0.
  - Address 14 reads PCIF2.
